psram_qpi_master: RTL and testbench
===================================

PSRAM_QPI_MASTER -- requirements
Module: psram_qpi_master

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clock and resetn.
REQ-002 SHALL have ports, clock and reset first:
- clock  in  1  system clock
- resetn  in  1  async active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  24  byte address; bits [1:0] ignored
- req_wdata  in  32  write word, little-endian lanes
- req_wstrb  in  4  byte lanes for writes
- resp_valid  out  1  one-cycle response pulse; no back-pressure
- resp_err  out  1  qualifies resp_valid
- resp_rdata  out  32  read word
- sck  out  1  PSRAM serial clock
- ce_n  out  1  PSRAM chip enable, active low
- dio_o  out  4  pad output
- dio_oe  out  4  pad output enable
- dio_i  in  4  pad input

Function
REQ-003 sck SHALL run at clock/2 while ce_n is low: low one cycle, high one cycle; sck SHALL be 0 whenever ce_n is 1.
REQ-004 dio_o SHALL change only in cycles where sck goes 1->0 or ce_n falls; the device samples on sck rise.
REQ-005 After reset release, SHALL send the QPI-enter command 0x35 MSB-first on dio_o[0] only (dio_oe=4'b0001), 8 sck periods (16 cycles), then raise ce_n.
REQ-006 req_ready SHALL be 0 during QPI entry and any transaction, and 1 only in IDLE.
REQ-007 FSM states SHALL be: INIT_QPI, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP.
- INIT_QPI->GAP after 8 bits.
- IDLE->CMD on accept.
- CMD->ADDR after 2 nibbles.
- ADDR->DUMMY (read) or WDATA (write) after 6 nibbles.
- DUMMY->RDATA after 6 sck.
- RDATA->GAP after 8 nibbles.
- WDATA->GAP after 2/4/8 nibbles.
- GAP->IDLE after 2 cycles with ce_n=1.
REQ-008 Command nibbles SHALL be 0xEB for read and 0x38 for write, high nibble first, all four lines driven.
REQ-009 Address SHALL be sent as 6 nibbles, MSB first. Read address = {req_addr[23:2],2'b00}. Write address = {req_addr[23:2],off}, where off = lowest set wstrb bit.
REQ-010 Legal wstrb values SHALL map as follows:
- 0001, 0010, 0100, 1000 -> 1 byte (2 nibbles).
- 0011, 1100 -> 2 bytes (4 nibbles).
- 1111 -> 4 bytes (8 nibbles).
REQ-011 Data nibble order SHALL be: lowest addressed byte first, high nibble before low nibble; write bytes are taken from the selected lanes.
REQ-012 dio_oe SHALL be 4'b0000 during DUMMY and RDATA, and 4'b1111 in CMD, ADDR and WDATA.
REQ-013 Read nibbles SHALL be sampled from dio_i on the clock edge where sck goes 1->0. resp_rdata SHALL be assembled as {b3,b2,b1,b0}, b0 being the first byte received.
REQ-014 A write with an illegal or zero wstrb SHALL start no bus transaction, and SHALL pulse resp_valid=1 with resp_err=1 one cycle after acceptance.
REQ-015 resp_valid SHALL pulse in the first cycle ce_n is back high. Latency from accept edge to resp_valid:
- read 45 cycles
- write 1 byte 21 cycles
- write 2 bytes 25 cycles
- write 4 bytes 33 cycles
REQ-016 resp_rdata SHALL hold its value until the next read response; resp_err=0 on all legal responses.
REQ-017 req_valid while req_ready=0 SHALL be ignored with no side effects; request fields are captured only on acceptance.

Reset
REQ-018 resetn low SHALL asynchronously force the following, even mid-transaction:
- ce_n=1, sck=0, dio_oe=0, dio_o=0
- req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0
- state INIT_QPI
REQ-019 Any interrupted transaction SHALL produce no response; QPI entry SHALL be re-run after release.

Structure
REQ-020 Package psram_pkg SHALL hold:
- state enum
- CMD_QPI_EN=0x35, CMD_RD=0xEB, CMD_WR=0x38
- ADDR_NIBBLES=6, DUMMY_SCK=6, GAP_CYCLES=2
REQ-021 One sub-module, psram_nibble_shift, SHALL implement a 32-bit load/shift-out/shift-in nibble register; FSM, counters and sck phase SHALL stay in the top.

Verification
REQ-022 Reset release -> dio_o[0] carries bits 0,0,1,1,0,1,0,1 on 8 sck rises; req_ready=1 exactly 18 cycles after release.
REQ-023 Read addr 0x000104, device returns nibbles 7,8,5,6,3,4,1,2 -> bus carries nibbles E,B,0,0,0,1,0,4; resp_rdata=0x12345678; resp_valid 45 cycles after accept.
REQ-024 Write addr 0x000020, wstrb=0100, wdata=0xAABBCCDD -> address 0x000022, data nibbles B,B; resp_valid at 21 cycles, resp_err=0.
REQ-025 Write wstrb=1111, wdata=0x11223344 -> data nibbles 4,4,3,3,2,2,1,1; write wstrb=0101 -> ce_n stays 1, resp_err=1 one cycle after accept.
REQ-026 Assert resetn during RDATA of a read -> ce_n=1 the same cycle, no resp_valid; after release, QPI entry repeats and the next read completes correctly.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types, command opcodes and timing constants for the QPI PSRAM master.
// The helper functions decode write strobes and reorder bytes for the nibble bus.
package psram_pkg;

  typedef enum logic [2:0] {
    INIT_QPI = 3'd0,
    IDLE     = 3'd1,
    CMD      = 3'd2,
    ADDR     = 3'd3,
    DUMMY    = 3'd4,
    RDATA    = 3'd5,
    WDATA    = 3'd6,
    GAP      = 3'd7
  } psram_state_e;

  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_RD     = 8'hEB;
  localparam logic [7:0] CMD_WR     = 8'h38;

  localparam int ADDR_NIBBLES = 6;
  localparam int DUMMY_SCK    = 6;
  localparam int GAP_CYCLES   = 2;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_INIT_LAST  = 5'd15;
  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = 5'd3;
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST  = CNT_W'(2 * ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_DUMMY_LAST = CNT_W'(2 * DUMMY_SCK - 1);
  localparam logic [CNT_W-1:0] CNT_RDATA_LAST = 5'd15;
  localparam logic [CNT_W-1:0] CNT_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  // Number of data nibbles for a write strobe; zero marks an unsupported pattern.
  function automatic logic [3:0] wstrb_nibbles(input logic [3:0] wstrb);
    logic [3:0] n;
    case (wstrb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: n = 4'd2;
      4'b0011, 4'b1100:                   n = 4'd4;
      4'b1111:                            n = 4'd8;
      default:                            n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] wstrb_offset(input logic [3:0] wstrb);
    logic [1:0] off;
    if (wstrb[0])      off = 2'd0;
    else if (wstrb[1]) off = 2'd1;
    else if (wstrb[2]) off = 2'd2;
    else               off = 2'd3;
    return off;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/psram_nibble_shift.sv
// 32-bit nibble register: parallel load, MSB-nibble-first shift out, and
// shift in at the bottom; both shifts move the word up by one nibble.
module psram_nibble_shift
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_out,
  input  logic        shift_in,
  input  logic [3:0]  nib_in,
  output logic [31:0] data
);

  logic [31:0] data_r;

  // Shift register state; load has priority over either shift.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_r <= 32'h0000_0000;
    end else if (load) begin
      data_r <= load_data;
    end else if (shift_in) begin
      data_r <= {data_r[27:0], nib_in};
    end else if (shift_out) begin
      data_r <= {data_r[27:0], 4'h0};
    end else begin
      data_r <= data_r;
    end
  end

  assign data = data_r;

endmodule

// File: rtl/psram_qpi_master.sv
// Single-request QPI PSRAM master: enters QPI mode after reset, then runs
// quad read (0xEB, 6 dummy clocks) and quad write (0x38) of 1, 2 or 4 bytes.
module psram_qpi_master
  import psram_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_o,
  output logic [3:0]  dio_oe,
  input  logic [3:0]  dio_i
);

  psram_state_e state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] wdata_last_s;

  logic        we_r;
  logic [3:0]  nibs_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;
  logic        pend_r;
  logic        err_r;

  logic        ce_n_r, sck_r, rd_out_r, req_ready_r;
  logic        resp_valid_r, resp_err_r;
  logic [31:0] resp_rdata_r;
  logic [3:0]  dio_o_r, dio_oe_r;

  logic        accept_s, req_bad_s, active_s;
  logic [3:0]  req_nibs_s;
  logic [1:0]  req_off_s;
  logic [23:0] req_addr_s;
  logic [1:0]  addr_lo_unused_s;
  logic [3:0]  dio_o_s, dio_oe_s;

  logic        sr_load_s, sr_shift_out_s, sr_shift_in_s;
  logic [31:0] sr_load_data_s, sr_data_s;

  assign accept_s         = req_valid && req_ready_r;
  assign req_nibs_s       = wstrb_nibbles(req_wstrb);
  assign req_off_s        = wstrb_offset(req_wstrb);
  assign req_bad_s        = req_we && (req_nibs_s == 4'd0);
  assign req_addr_s       = {req_addr[23:2], (req_we ? req_off_s : 2'b00)};
  assign addr_lo_unused_s = req_addr[1:0];
  assign wdata_last_s     = {nibs_r, 1'b0} - 5'd1;
  // Outputs lag the state by one cycle, so read nibbles are taken where the pins show sck falling.
  assign sr_shift_in_s    = rd_out_r && sck_r;

  // Next-state decode; every active state has an even length so the sck phase stays aligned.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT_QPI: if (cnt_r == CNT_INIT_LAST) state_s = GAP;   else state_s = INIT_QPI;
      IDLE: begin
        if (accept_s) begin
          if (req_bad_s) state_s = GAP;
          else           state_s = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD:   if (cnt_r == CNT_CMD_LAST)   state_s = ADDR;  else state_s = CMD;
      ADDR: begin
        if (cnt_r == CNT_ADDR_LAST) state_s = we_r ? WDATA : DUMMY;
        else                        state_s = ADDR;
      end
      DUMMY: if (cnt_r == CNT_DUMMY_LAST) state_s = RDATA; else state_s = DUMMY;
      RDATA: if (cnt_r == CNT_RDATA_LAST) state_s = GAP;   else state_s = RDATA;
      WDATA: if (cnt_r == wdata_last_s)   state_s = GAP;   else state_s = WDATA;
      GAP:   if (cnt_r == CNT_GAP_LAST)   state_s = IDLE;  else state_s = GAP;
      default: state_s = INIT_QPI;
    endcase
  end

  // State register and per-state cycle counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= INIT_QPI;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_s;
      if ((state_s != state_r) || (state_r == IDLE)) cnt_r <= 5'd0;
      else                                           cnt_r <= cnt_r + 5'd1;
    end
  end

  // Pin values implied by the current state; registered below.
  always_comb begin
    active_s = 1'b0;
    dio_o_s  = 4'h0;
    dio_oe_s = 4'h0;
    case (state_r)
      INIT_QPI: begin
        active_s = 1'b1;
        dio_o_s  = {3'b000, CMD_QPI_EN[3'd7 - cnt_r[3:1]]};
        dio_oe_s = 4'b0001;
      end
      CMD, ADDR, WDATA: begin
        active_s = 1'b1;
        dio_o_s  = sr_data_s[31:28];
        dio_oe_s = 4'b1111;
      end
      DUMMY, RDATA: begin
        active_s = 1'b1;
      end
      default: begin
        active_s = 1'b0;
      end
    endcase
  end

  // Shift register control: header on accept, write data at the end of ADDR.
  always_comb begin
    sr_load_s      = 1'b0;
    sr_load_data_s = 32'h0000_0000;
    sr_shift_out_s = 1'b0;
    if (accept_s) begin
      sr_load_s      = 1'b1;
      sr_load_data_s = {(req_we ? CMD_WR : CMD_RD), req_addr_s};
    end else if ((state_r == ADDR) && (cnt_r == CNT_ADDR_LAST) && we_r) begin
      sr_load_s      = 1'b1;
      sr_load_data_s = bswap32(wdata_r >> {off_r, 3'b000});
    end else if (cnt_r[0] && ((state_r == CMD) || (state_r == ADDR) || (state_r == WDATA))) begin
      sr_shift_out_s = 1'b1;
    end else begin
      sr_shift_out_s = 1'b0;
    end
  end

  psram_nibble_shift u_shift (
    .clock     (clock),
    .resetn    (resetn),
    .load      (sr_load_s),
    .load_data (sr_load_data_s),
    .shift_out (sr_shift_out_s),
    .shift_in  (sr_shift_in_s),
    .nib_in    (dio_i),
    .data      (sr_data_s)
  );

  // Request fields captured on acceptance; pend_r marks a response still owed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      we_r    <= 1'b0;
      nibs_r  <= 4'd0;
      off_r   <= 2'd0;
      wdata_r <= 32'h0000_0000;
      pend_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      we_r    <= req_we;
      nibs_r  <= req_nibs_s;
      off_r   <= req_off_s;
      wdata_r <= req_wdata;
      pend_r  <= 1'b1;
      err_r   <= req_bad_s;
    end else if ((state_r == GAP) && (cnt_r == 5'd0)) begin
      pend_r  <= 1'b0;
    end else begin
      pend_r  <= pend_r;
    end
  end

  // Registered pins and response.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ce_n_r       <= 1'b1;
      sck_r        <= 1'b0;
      dio_o_r      <= 4'h0;
      dio_oe_r     <= 4'h0;
      rd_out_r     <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      ce_n_r       <= ~active_s;
      sck_r        <= active_s && cnt_r[0];
      dio_o_r      <= dio_o_s;
      dio_oe_r     <= dio_oe_s;
      rd_out_r     <= (state_r == RDATA);
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_r == GAP) && (cnt_r == 5'd0) && pend_r;
      resp_err_r   <= (state_r == GAP) && (cnt_r == 5'd0) && pend_r && err_r;
      if (sr_shift_in_s && (state_r == GAP)) resp_rdata_r <= bswap32({sr_data_s[27:0], dio_i});
      else                                   resp_rdata_r <= resp_rdata_r;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign sck        = sck_r;
  assign ce_n       = ce_n_r;
  assign dio_o      = dio_o_r;
  assign dio_oe     = dio_oe_r;

endmodule

// File: tb/tb_psram_qpi_master.sv
// Directed bench for psram_qpi_master: a tiny PSRAM model records driven
// nibbles on each sck rise and returns read nibbles for the data phase.
module tb_psram_qpi_master;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_we;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sck, ce_n;
  logic [3:0]  dio_o, dio_oe;
  logic [3:0]  dio_i = 4'h0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] bus_q[$];
  logic       init_q[$];
  logic [3:0] rd_nibs[8];
  int         rise_cnt = 0;
  logic       sck_d = 1'b0;
  int         resp_cnt = 0;

  psram_qpi_master dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .sck        (sck),
    .ce_n       (ce_n),
    .dio_o      (dio_o),
    .dio_oe     (dio_oe),
    .dio_i      (dio_i)
  );

  always #5 clock = ~clock;

  // Device model and bus recorder, sampled mid-cycle.
  always @(negedge clock) begin
    if (resp_valid === 1'b1) resp_cnt++;
    if (ce_n !== 1'b0) begin
      rise_cnt = 0;
    end else if (sck === 1'b1 && sck_d === 1'b0) begin
      rise_cnt++;
      if (dio_oe == 4'hF) bus_q.push_back(dio_o);
      else if (dio_oe == 4'b0001) init_q.push_back(dio_o[0]);
      if (rise_cnt >= 15 && rise_cnt <= 22) dio_i = rd_nibs[rise_cnt - 15];
    end
    sck_d = sck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_bus(input int s, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = {v[27:0], ((s + i) < bus_q.size()) ? bus_q[s + i] : 4'h0};
    return v;
  endfunction

  function automatic logic [31:0] pack_init();
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < init_q.size(); i++) v = {v[30:0], init_q[i]};
    return v;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic do_req(input logic we, input logic [23:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic hold_busy,
                        output int lat, output logic err, output logic [31:0] rdata);
    int n;
    wait_ready(n);
    check("ready_before_req", {31'h0, req_ready}, 32'h1);
    bus_q.delete();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clock);
    #1;
    if (hold_busy) begin
      req_we = 1'b1; req_addr = 24'hFFFFFC; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    end else begin
      req_valid = 1'b0;
    end
    lat = -1; err = 1'b0; rdata = 32'h0;
    for (int c = 0; c <= 100; c++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) begin
        lat = c; err = resp_err; rdata = resp_rdata;
        break;
      end
    end
    req_valid = 1'b0;
    @(negedge clock);
    check("resp_pulse_width", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    int n, lat, rc0;
    logic err;
    logic [31:0] rd;

    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 24'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    repeat (3) @(negedge clock);
    check("rst_ce_n", {31'h0, ce_n}, 32'h1);
    check("rst_sck", {31'h0, sck}, 32'h0);
    check("rst_oe", {28'h0, dio_oe}, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    init_q.delete();
    resetn = 1'b1;
    wait_ready(n);
    check("init_ready_lat", n, 18);
    check("init_bit_count", init_q.size(), 8);
    check("init_bits", pack_init(), 32'h35);

    // Read with request fields changing while busy
    rd_nibs = '{4'h7, 4'h8, 4'h5, 4'h6, 4'h3, 4'h4, 4'h1, 4'h2};
    do_req(1'b0, 24'h000104, 32'h0, 4'h0, 1'b1, lat, err, rd);
    check("rd_lat", lat, 45);
    check("rd_hdr", pack_bus(0, 8), 32'hEB000104);
    check("rd_nib_count", bus_q.size(), 8);
    check("rd_data", rd, 32'h12345678);
    check("rd_err", {31'h0, err}, 32'h0);

    do_req(1'b1, 24'h000020, 32'hAABBCCDD, 4'b0100, 1'b0, lat, err, rd);
    check("wr1_lat", lat, 21);
    check("wr1_hdr", pack_bus(0, 8), 32'h38000022);
    check("wr1_data", pack_bus(8, 2), 32'hBB);
    check("wr1_nib_count", bus_q.size(), 10);
    check("wr1_err", {31'h0, err}, 32'h0);

    do_req(1'b1, 24'h000100, 32'h11223344, 4'b1111, 1'b0, lat, err, rd);
    check("wr4_lat", lat, 33);
    check("wr4_hdr", pack_bus(0, 8), 32'h38000100);
    check("wr4_data", pack_bus(8, 8), 32'h44332211);
    check("wr4_nib_count", bus_q.size(), 16);

    do_req(1'b1, 24'h000204, 32'hCAFEBABE, 4'b0011, 1'b0, lat, err, rd);
    check("wr2_lat", lat, 25);
    check("wr2_hdr", pack_bus(0, 8), 32'h38000204);
    check("wr2_data", pack_bus(8, 4), 32'hBEBA);

    do_req(1'b1, 24'h00003F, 32'h5A000000, 4'b1000, 1'b0, lat, err, rd);
    check("wr_lane3_lat", lat, 21);
    check("wr_lane3_hdr", pack_bus(0, 8), 32'h3800003F);
    check("wr_lane3_data", pack_bus(8, 2), 32'h5A);

    do_req(1'b1, 24'h000040, 32'h12345678, 4'b0101, 1'b0, lat, err, rd);
    check("bad_wstrb_lat", lat, 1);
    check("bad_wstrb_err", {31'h0, err}, 32'h1);
    check("bad_wstrb_no_bus", bus_q.size(), 0);

    do_req(1'b1, 24'h000040, 32'h12345678, 4'b0000, 1'b0, lat, err, rd);
    check("zero_wstrb_lat", lat, 1);
    check("zero_wstrb_err", {31'h0, err}, 32'h1);
    check("zero_wstrb_no_bus", bus_q.size(), 0);
    check("rdata_hold", resp_rdata, 32'h12345678);

    // Reset in the middle of the read data phase
    wait_ready(n);
    rd_nibs = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000300;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (35) @(negedge clock);
    check("mid_rd_ce_low", {31'h0, ce_n}, 32'h0);
    rc0 = resp_cnt;
    resetn = 1'b0;
    #1;
    check("mid_rst_ce_n", {31'h0, ce_n}, 32'h1);
    check("mid_rst_sck", {31'h0, sck}, 32'h0);
    check("mid_rst_pins", {24'h0, dio_oe, dio_o}, 32'h0);
    check("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    check("mid_rst_rdata", resp_rdata, 32'h0);
    repeat (3) @(negedge clock);
    init_q.delete();
    resetn = 1'b1;
    wait_ready(n);
    check("rerun_ready_lat", n, 18);
    check("rerun_init_bits", pack_init(), 32'h35);
    check("no_resp_after_rst", resp_cnt, rc0);

    rd_nibs = '{4'hE, 4'hF, 4'hB, 4'hE, 4'hA, 4'hD, 4'hD, 4'hE};
    do_req(1'b0, 24'hABCDEF, 32'h0, 4'h0, 1'b0, lat, err, rd);
    check("rd2_lat", lat, 45);
    check("rd2_hdr", pack_bus(0, 8), 32'hEBABCDEC);
    check("rd2_data", rd, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
